control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list, one per line (name, direction, width, meaning), clock and reset first:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- OpCode  input  6  instruction opcode field.
- RegDst  output  1  1 = write register from rd, 0 = from rt.
- ALUSrc  output  1  1 = ALU operand B is the immediate.
- MemToReg  output  1  1 = writeback data from memory.
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  data memory write enable.
- MemRead  output  1  data memory read enable.
- BranchEq  output  1  branch if equal.
- BranchGr  output  1  branch if greater.
- Jump  output  1  unconditional jump.
- ExtOp  output  1  1 = sign-extend immediate, 0 = zero-extend.
- AluOp  output  3  ALU operation class.

Function
REQ-003 All outputs SHALL be registered; decode of OpCode SHALL appear on the outputs one clk cycle after it is sampled (latency 1).
REQ-004 The AluOp encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 slt, 111 R-type (funct decode downstream); 101 and 110 are never driven.
REQ-005 The decode table SHALL be as follows. Column order: RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, BranchEq, BranchGr, Jump, ExtOp, AluOp.
- 0 R-type: 1 0 0 1 0 0 0 0 0 0 111
- 1 addi: 0 1 0 1 0 0 0 0 0 1 000
- 2 lw: 0 1 1 1 0 1 0 0 0 1 000
- 3 sw: 0 1 0 0 1 0 0 0 0 1 000
- 4 beq: 0 0 0 0 0 0 1 0 0 1 001
- 5 bgt: 0 0 0 0 0 0 0 1 0 1 001
- 6 j: 0 0 0 0 0 0 0 0 1 0 000
- 7 andi: 0 1 0 1 0 0 0 0 0 0 010
- 8 ori: 0 1 0 1 0 0 0 0 0 0 011
- 9 slti: 0 1 0 1 0 0 0 0 0 1 100
REQ-006 Opcodes 10-63 SHALL decode as a NOP: all outputs 0, AluOp 000.
REQ-007 At most one of MemWrite, BranchEq, BranchGr and Jump SHALL be 1 in any cycle.
REQ-008 MemRead and MemWrite SHALL never both be 1 in the same cycle.
REQ-009 The block SHALL have no internal state other than the output registers; the same OpCode held for consecutive cycles SHALL produce constant outputs.

Reset
REQ-010 While rst = 1 at a rising clk edge, every output SHALL be loaded with 0, including AluOp = 000 and IllegalOp when present.
REQ-011 rst SHALL take priority over OpCode decode.
REQ-012 In the first edge after rst falls, the block SHALL register the decode of the current OpCode.
REQ-013 Reset asserted mid-stream SHALL clear the outputs at that edge with no residual effect afterwards.

Configuration
REQ-014 With macro CU_ILLEGAL_OP_EN defined, the block SHALL add output port IllegalOp (1 bit, registered, latency 1), asserted 1 for opcodes 10-63 and 0 otherwise.
REQ-015 Without CU_ILLEGAL_OP_EN, the IllegalOp port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset: rst = 1 for 2 edges with OpCode = 2 -> all outputs 0.
- OpCode = 2, rst = 0 -> after 1 edge: ALUSrc = MemToReg = RegWrite = MemRead = ExtOp = 1, other flags 0, AluOp = 000.
- OpCode = 3 -> after 1 edge: ALUSrc = MemWrite = ExtOp = 1, RegWrite = 0, other flags 0, AluOp = 000.
- OpCode = 6 -> after 1 edge: Jump = 1, all other flags 0, AluOp = 000.
- OpCode = 0 -> after 1 edge: RegDst = RegWrite = 1, other flags 0, AluOp = 111.
- OpCode = 63 -> after 1 edge: all outputs 0, and IllegalOp = 1 when CU_ILLEGAL_OP_EN is defined.
- Apply rst = 1 during OpCode = 0 -> outputs 0 at that edge; after rst = 0, R-type decode returns 1 edge later.

Source files
------------

// File: rtl/control_unit.sv
// Single-cycle datapath control decoder: registered decode of a 6-bit opcode (latency 1).
// Optional IllegalOp output for opcodes 10-63 when CU_ILLEGAL_OP_EN is defined.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       BranchEq,
  output logic       BranchGr,
  output logic       Jump,
  output logic       ExtOp,
  output logic [2:0] AluOp
`ifdef CU_ILLEGAL_OP_EN
  ,
  output logic       IllegalOp
`endif
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_ADDI  = 6'd1,
    OP_LW    = 6'd2,
    OP_SW    = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BGT   = 6'd5,
    OP_J     = 6'd6,
    OP_ANDI  = 6'd7,
    OP_ORI   = 6'd8,
    OP_SLTI  = 6'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_RTYPE = 3'b111
  } aluop_e;

  typedef struct packed {
    logic   regDst;
    logic   aluSrc;
    logic   memToReg;
    logic   regWrite;
    logic   memWrite;
    logic   memRead;
    logic   branchEq;
    logic   branchGr;
    logic   jump;
    logic   extOp;
    aluop_e aluOp;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrlQ;

  // Unlisted opcodes fall through to the all-zero default, which is the NOP encoding.
  always_comb begin
    dec = '0;
    case (OpCode)
      OP_RTYPE: begin
        dec.regDst   = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp    = ALU_RTYPE;
      end
      OP_ADDI: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_ADD;
      end
      OP_LW: begin
        dec.aluSrc   = 1'b1;
        dec.memToReg = 1'b1;
        dec.regWrite = 1'b1;
        dec.memRead  = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_ADD;
      end
      OP_SW: begin
        dec.aluSrc   = 1'b1;
        dec.memWrite = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branchEq = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_SUB;
      end
      OP_BGT: begin
        dec.branchGr = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_SUB;
      end
      OP_J: begin
        dec.jump     = 1'b1;
        dec.aluOp    = ALU_ADD;
      end
      OP_ANDI: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp    = ALU_AND;
      end
      OP_ORI: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp    = ALU_OR;
      end
      OP_SLTI: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.extOp    = 1'b1;
        dec.aluOp    = ALU_SLT;
      end
      default: dec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ctrlQ <= '0;
    else     ctrlQ <= dec;
  end

  assign RegDst   = ctrlQ.regDst;
  assign ALUSrc   = ctrlQ.aluSrc;
  assign MemToReg = ctrlQ.memToReg;
  assign RegWrite = ctrlQ.regWrite;
  assign MemWrite = ctrlQ.memWrite;
  assign MemRead  = ctrlQ.memRead;
  assign BranchEq = ctrlQ.branchEq;
  assign BranchGr = ctrlQ.branchGr;
  assign Jump     = ctrlQ.jump;
  assign ExtOp    = ctrlQ.extOp;
  assign AluOp    = ctrlQ.aluOp;

`ifdef CU_ILLEGAL_OP_EN
  logic decIllegal;

  always_comb begin
    decIllegal = (OpCode > OP_SLTI);
  end

  always_ff @(posedge clk) begin
    if (rst) IllegalOp <= 1'b0;
    else     IllegalOp <= decIllegal;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes expected decode, a monitor pops and compares.
// Covers the optional IllegalOp output when CU_ILLEGAL_OP_EN is defined.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] OpCode;
  logic       RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead;
  logic       BranchEq, BranchGr, Jump, ExtOp;
  logic [2:0] AluOp;
`ifdef CU_ILLEGAL_OP_EN
  logic       IllegalOp;
`endif

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .OpCode   (OpCode),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .BranchEq (BranchEq),
    .BranchGr (BranchGr),
    .Jump     (Jump),
    .ExtOp    (ExtOp),
    .AluOp    (AluOp)
`ifdef CU_ILLEGAL_OP_EN
    ,
    .IllegalOp(IllegalOp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {RegDst..ExtOp (10 bits), AluOp (3 bits)} plus illegal flag.
  typedef struct {
    logic [12:0] ctrl;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];
  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  logic [12:0] specTable [10];

  initial begin
    specTable[0] = 13'b1_0_0_1_0_0_0_0_0_0_111;
    specTable[1] = 13'b0_1_0_1_0_0_0_0_0_1_000;
    specTable[2] = 13'b0_1_1_1_0_1_0_0_0_1_000;
    specTable[3] = 13'b0_1_0_0_1_0_0_0_0_1_000;
    specTable[4] = 13'b0_0_0_0_0_0_1_0_0_1_001;
    specTable[5] = 13'b0_0_0_0_0_0_0_1_0_1_001;
    specTable[6] = 13'b0_0_0_0_0_0_0_0_1_0_000;
    specTable[7] = 13'b0_1_0_1_0_0_0_0_0_0_010;
    specTable[8] = 13'b0_1_0_1_0_0_0_0_0_0_011;
    specTable[9] = 13'b0_1_0_1_0_0_0_0_0_1_100;
  end

  function automatic exp_t model(input logic r, input logic [5:0] op);
    exp_t e;
    e.ctrl    = '0;
    e.illegal = 1'b0;
    if (!r) begin
      if (op < 6'd10) e.ctrl = specTable[op];
      else            e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op);
    @(negedge clk);
    rst    = r;
    OpCode = op;
    expQ.push_back(model(r, op));
  endtask

  // Monitor: every cycle the registered outputs are valid one edge after stimulus.
  initial begin
    exp_t e;
    logic [12:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e   = expQ.pop_front();
        act = {RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead,
               BranchEq, BranchGr, Jump, ExtOp, AluOp};
        check("decode", act, e.ctrl);
`ifdef CU_ILLEGAL_OP_EN
        check("illegalOp", {12'd0, IllegalOp}, {12'd0, e.illegal});
`endif
        check("oneHotCtrl", {12'd0, ($countones({MemWrite, BranchEq, BranchGr, Jump}) <= 1)}, 13'd1);
        check("memRdWrExcl", {12'd0, (MemRead & MemWrite)}, 13'd0);
        check("aluOpLegal", {12'd0, (AluOp == 3'b101 || AluOp == 3'b110)}, 13'd0);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    OpCode = 6'd2;
    // Directed scenarios
    step(1'b1, 6'd2);
    step(1'b1, 6'd2);
    step(1'b0, 6'd2);
    step(1'b0, 6'd3);
    step(1'b0, 6'd6);
    step(1'b0, 6'd0);
    step(1'b0, 6'd63);
    step(1'b0, 6'd10);
    step(1'b0, 6'd9);
    step(1'b1, 6'd0);
    step(1'b0, 6'd0);
    step(1'b0, 6'd0);
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 6'(i));
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 6'd4);
    // Random stream with occasional mid-stream reset and repeated opcodes
    for (int unsigned i = 0; i < 400; i++) begin
      logic r;
      logic [5:0] op;
      r  = ($urandom_range(0, 15) == 0);
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(10, 63)) : 6'($urandom_range(0, 9));
      step(r, op);
      if ($urandom_range(0, 7) == 0) step(1'b0, op);
    end
    // Bounded drain of the scoreboard
    for (int unsigned k = 0; k < 5 && expQ.size() != 0; k++) @(posedge clk);
    #2;
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL drain: actual %0d pending required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
